freq_meter: RTL and testbench

- Gated edge counter that measures the frequency of the divided clock produced by the clock-divider stage.
- Counts rising edges of `sig_in` over a fixed window of `GATE_CYCLES` system-clock cycles.
- Latches the count, with a one-cycle valid pulse, for the display/readout stage downstream.
- Supports continuous re-measurement and single-shot mode.

---
 rtl/freq_meter_pkg.sv | 25 ++
 rtl/freq_meter_edge_sync.sv | 34 +++
 rtl/freq_meter.sv | 148 ++++++++++++++
 tb/tb_freq_meter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared types, default parameters and helpers for freq_meter.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_GATE_CYCLES = 100000000;
    localparam int DEF_COUNT_W     = 24;

    // Increment that sticks at max_val; counters up to 32 bits wide use this.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_meter_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync
// Description : Two-flop synchroniser plus delay flop; one-cycle rising-edge
//               pulse for an asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~sync3_q;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Gated rising-edge counter; counts sig_in edges over a fixed
//               window of GATE_CYCLES clocks and latches the result.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int COUNT_W     = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sig_in,
    input  logic               run,
    input  logic               single,
    output logic [COUNT_W-1:0] meas_count,
    output logic               meas_ovf,
    output logic               meas_valid,
    output logic               busy
);

    localparam int                GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

    state_e               state_q, state_d;
    logic [GW-1:0]        gate_cnt_q, gate_cnt_d;
    logic [COUNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                 ovf_acc_q, ovf_acc_d;
    logic                 single_q, single_d;
    logic [COUNT_W-1:0]   meas_count_q, meas_count_d;
    logic                 meas_ovf_q, meas_ovf_d;
    logic                 meas_valid_q, meas_valid_d;
    logic                 busy_q, busy_d;

    logic                 rise;
    logic                 rise_sat;
    logic [COUNT_W-1:0]   edge_next;

    edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sig_in),
        .rise_o (rise)
    );

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        ovf_acc_d    = ovf_acc_q;
        single_d     = single_q;
        meas_count_d = meas_count_q;
        meas_ovf_d   = meas_ovf_q;
        meas_valid_d = 1'b0;

        // An edge arriving with the counter already full is recorded as overflow.
        rise_sat  = rise && (edge_cnt_q == CNT_MAX);
        edge_next = rise ? COUNT_W'(sat_inc(32'(edge_cnt_q), 32'(CNT_MAX)))
                         : edge_cnt_q;

        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                ovf_acc_d  = 1'b0;
                if (run) begin
                    state_d  = GATE;
                    single_d = single;
                end
            end
            GATE: begin
                if (gate_cnt_q == GATE_LAST) begin
                    // Terminal cycle: its own edge still belongs to this window.
                    meas_count_d = edge_next;
                    meas_ovf_d   = ovf_acc_q | rise_sat;
                    meas_valid_d = 1'b1;
                    gate_cnt_d   = '0;
                    edge_cnt_d   = '0;
                    ovf_acc_d    = 1'b0;
                    if (single_q) begin
                        state_d = HOLD;
                    end else if (run) begin
                        state_d = GATE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!run) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_acc_d  = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    edge_cnt_d = edge_next;
                    ovf_acc_d  = ovf_acc_q | rise_sat;
                end
            end
            HOLD: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                ovf_acc_d  = 1'b0;
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == GATE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            ovf_acc_q    <= 1'b0;
            single_q     <= 1'b0;
            meas_count_q <= '0;
            meas_ovf_q   <= 1'b0;
            meas_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            ovf_acc_q    <= ovf_acc_d;
            single_q     <= single_d;
            meas_count_q <= meas_count_d;
            meas_ovf_q   <= meas_ovf_d;
            meas_valid_q <= meas_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign meas_count = meas_count_q;
    assign meas_ovf   = meas_ovf_q;
    assign meas_valid = meas_valid_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_meter
// Description : Self-checking bench for freq_meter (24-bit and 4-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

    localparam int G = 4096;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic        run;
    logic        single;
    logic [23:0] meas_count;
    logic        meas_ovf;
    logic        meas_valid;
    logic        busy;
    logic [3:0]  meas_count4;
    logic        meas_ovf4;
    logic        meas_valid4;
    logic        busy4;

    logic        man_sig;
    logic        div_en;
    logic [3:0]  tap;
    logic [9:0]  div_cnt;
    logic [9:0]  div_off;
    logic [9:0]  div_val;

    int          cyc;
    logic        sig_prev;
    bit          rose_at [0:131071];
    int          checks;
    int          errors;

    freq_meter #(.GATE_CYCLES(G), .COUNT_W(24)) u_dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .run(run), .single(single),
        .meas_count(meas_count), .meas_ovf(meas_ovf),
        .meas_valid(meas_valid), .busy(busy)
    );

    freq_meter #(.GATE_CYCLES(G), .COUNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .run(run), .single(single),
        .meas_count(meas_count4), .meas_ovf(meas_ovf4),
        .meas_valid(meas_valid4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running divider on the same clock; sig_in is one of its taps or a manual level.
    initial div_cnt = 10'd0;
    always @(negedge clk) div_cnt <= div_cnt + 10'd1;
    assign div_val = div_cnt + div_off;
    assign sig_in  = div_en ? div_val[tap] : man_sig;

    // cyc == n between posedge n and posedge n+1; a rise seen at posedge k happened in cycle k-1.
    initial begin
        cyc      = 0;
        sig_prev = 1'b0;
    end
    always @(posedge clk) begin
        if (sig_in && !sig_prev) rose_at[cyc] <= 1'b1;
        sig_prev <= sig_in;
        cyc      <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rise in cycle r is counted in cycle r+2; the window closing with valid at v spans [v-G, v-1].
    function automatic int exp_edges(input int v);
        int n = 0;
        for (int r = v - G - 2; r <= v - 3; r++) begin
            if (r >= 0 && rose_at[r]) n++;
        end
        return n;
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output int vcyc, output bit got);
        got  = 1'b0;
        vcyc = cyc;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                got  = 1'b1;
                vcyc = cyc;
                return;
            end
        end
    endtask

    task automatic check_win(input string tag, input int v, output int n);
        n = exp_edges(v);
        check({tag, "_cnt"},  32'(meas_count),  32'(n));
        check({tag, "_ovf"},  32'(meas_ovf),    32'(0));
        check({tag, "_cnt4"}, 32'(meas_count4), 32'((n > 15) ? 15 : n));
        check({tag, "_ovf4"}, 32'(meas_ovf4),   32'((n > 15) ? 1 : 0));
        check({tag, "_v4"},   32'(meas_valid4), 32'(1));
    endtask

    initial begin
        int a, v, vp, n, c, rot, nom;
        bit got;
        int taps [3];

        taps    = '{7, 8, 9};
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        run     = 1'b0;
        single  = 1'b0;
        man_sig = 1'b0;
        div_en  = 1'b0;
        tap     = 4'd4;
        div_off = 10'($urandom);

        repeat (4) @(negedge clk);
        check("rst_cnt",   32'(meas_count),  32'(0));
        check("rst_ovf",   32'(meas_ovf),    32'(0));
        check("rst_valid", 32'(meas_valid),  32'(0));
        check("rst_busy",  32'(busy),        32'(0));
        check("rst_cnt4",  32'(meas_count4), 32'(0));
        rst = 1'b0;
        repeat ($urandom_range(3, 40)) @(negedge clk);

        // Code 00 (tap 4): 128 edges per window, saturates the 4-bit build.
        div_en = 1'b1;
        tap    = 4'd4;
        run    = 1'b1;
        a      = cyc;
        @(negedge clk);
        check("gate_busy", 32'(busy), 32'(1));
        wait_until(a + G - 1);
        div_en = 1'b0;
        wait_valid(G + 10, v, got);
        check("w1_seen", 32'(got), 32'(1));
        check("w1_time", 32'(v), 32'(a + G + 1));
        check_win("w1", v, n);
        check("w1_range", 32'((n >= 127) && (n <= 129)), 32'(1));
        check("w1_sat4", 32'(meas_count4), 32'(15));
        check("w1_ovf4", 32'(meas_ovf4), 32'(1));
        @(negedge clk);
        check("w1_pulse", 32'(meas_valid), 32'(0));
        vp = v;
        wait_valid(G + 10, v, got);
        check("w2_seen", 32'(got), 32'(1));
        check("w2_period", 32'(v - vp), 32'(G));
        check_win("w2", v, n);
        check("w2_zero4", 32'(meas_count4), 32'(0));
        check("w2_nov4", 32'(meas_ovf4), 32'(0));

        // Sweep the remaining taps in a random rotation, two windows each.
        rot = $urandom_range(0, 2);
        for (int k = 0; k < 3; k++) begin
            tap    = 4'(taps[(k + rot) % 3]);
            div_en = 1'b1;
            nom    = G >> (tap + 1);
            for (int w = 0; w < 2; w++) begin
                vp = v;
                if (k == 2 && w == 1) begin
                    wait_until(vp + G - 2);
                    div_en = 1'b0;
                end
                wait_valid(G + 10, v, got);
                check("tap_seen", 32'(got), 32'(1));
                check("tap_period", 32'(v - vp), 32'(G));
                check_win("tap", v, n);
                if (w == 1) check("tap_range", 32'((n + 1 >= nom) && (n <= nom + 1)), 32'(1));
            end
        end

        // Boundary: edge on the terminal cycle, then on the first cycle of a window.
        vp = v;
        wait_until(vp + G - 3);
        man_sig = 1'b1;
        wait_valid(G + 10, v, got);
        check("bA_period", 32'(v - vp), 32'(G));
        check_win("bA", v, n);
        check("bA_one", 32'(meas_count), 32'(1));
        vp = v;
        wait_until(vp + 100);
        man_sig = 1'b0;
        wait_until(vp + G - 2);
        man_sig = 1'b1;
        wait_valid(G + 10, v, got);
        check_win("bB", v, n);
        check("bB_zero", 32'(meas_count), 32'(0));
        wait_valid(G + 10, v, got);
        check_win("bC", v, n);
        check("bC_one", 32'(meas_count), 32'(1));

        // Reset at gate_cnt = 2000.
        man_sig = 1'b0;
        div_en  = 1'b1;
        tap     = 4'd4;
        vp      = v;
        wait_until(vp + 2000);
        rst    = 1'b1;
        div_en = 1'b0;
        @(negedge clk);
        check("mr_cnt",   32'(meas_count),  32'(0));
        check("mr_ovf",   32'(meas_ovf),    32'(0));
        check("mr_valid", 32'(meas_valid),  32'(0));
        check("mr_busy",  32'(busy),        32'(0));
        check("mr_cnt4",  32'(meas_count4), 32'(0));
        check("mr_ovf4",  32'(meas_ovf4),   32'(0));
        rst    = 1'b0;
        div_en = 1'b1;
        a      = cyc;
        wait_valid(G + 10, v, got);
        check("mr_seen", 32'(got), 32'(1));
        check("mr_time", 32'(v), 32'(a + G + 1));
        check_win("mr", v, n);
        c = n;

        // Abort at gate_cnt = 1000.
        vp = v;
        wait_until(vp + 1000);
        run = 1'b0;
        @(negedge clk);
        check("ab_busy",  32'(busy),       32'(0));
        check("ab_valid", 32'(meas_valid), 32'(0));
        check("ab_cnt",   32'(meas_count), 32'(c));
        wait_valid(G + 200, v, got);
        check("ab_noval", 32'(got), 32'(0));
        check("ab_keep",  32'(meas_count), 32'(c));

        // Single-shot, then re-arm by toggling run.
        single = 1'b1;
        run    = 1'b1;
        a      = cyc;
        wait_valid(G + 10, v, got);
        check("ss1_seen", 32'(got), 32'(1));
        check("ss1_time", 32'(v), 32'(a + G + 1));
        check_win("ss1", v, n);
        @(negedge clk);
        check("ss1_busy", 32'(busy), 32'(0));
        wait_valid(G + 100, v, got);
        check("ss_hold_noval", 32'(got), 32'(0));
        check("ss_hold_busy", 32'(busy), 32'(0));
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        a   = cyc;
        wait_valid(G + 10, v, got);
        check("ss2_seen", 32'(got), 32'(1));
        check("ss2_time", 32'(v), 32'(a + G + 1));
        check_win("ss2", v, n);
        wait_valid(1000, v, got);
        check("ss2_noval", 32'(got), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
